// File: rtl/matmul_pkg.sv
// Shared FSM encoding and job-size defaults for the matmul job controller.
package matmul_pkg;

    localparam int N_BYTES_DEF  = 32;
    localparam int N_RESULT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        OUT     = 3'd5,
        FIN     = 3'd6
    } state_t;

    // Result addresses wrap within the 256-entry SRAM window.
    function automatic logic [7:0] rd_addr_of(input logic [7:0] base, input int idx);
        logic [31:0] idx_u;
        idx_u = idx;
        return base + idx_u[7:0];
    endfunction

endpackage

// File: rtl/matmul_ctrl.sv
// Sequences one matmul job: byte load into X buffer, compute, SRAM result read-back, result stream.
// Latency: first out_valid two edges after ALU_done is sampled when ry returns the cycle after the request.
// Backpressure: in_valid/in_ready on input; out_data held until out_ready, next read issued only after handshake.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int         N_BYTES  = N_BYTES_DEF,
    parameter int         N_RESULT = N_RESULT_DEF,
    parameter logic [7:0] RD_BASE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  X_load,
    output logic        valid_input,
    output logic        input_load_en,
    input  logic        xload_done,
    output logic        ALU_en,
    input  logic        ALU_done,
    output logic        cs_n,
    output logic [7:0]  rd_addr,
    input  logic        ry,
    input  logic [31:0] read_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam int IDX_W = (N_RESULT > 1) ? $clog2(N_RESULT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RESULT - 1);

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [IDX_W-1:0]   rd_idx;
    logic               accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            rd_idx        <= '0;
            in_ready      <= 1'b0;
            X_load        <= 8'h00;
            valid_input   <= 1'b0;
            input_load_en <= 1'b0;
            ALU_en        <= 1'b0;
            cs_n          <= 1'b1;
            rd_addr       <= 8'h00;
            out_valid     <= 1'b0;
            out_data      <= 32'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // Pulse-type outputs default inactive; states below raise them for one cycle.
            valid_input <= 1'b0;
            done        <= 1'b0;
            cs_n        <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= LOAD;
                        byte_cnt      <= '0;
                        in_ready      <= 1'b1;
                        input_load_en <= 1'b1;
                        busy          <= 1'b1;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        X_load      <= in_data;
                        valid_input <= 1'b1;
                        byte_cnt    <= byte_cnt + 1'b1;
                        if (byte_cnt == CNT_FULL - 1'b1) begin
                            in_ready <= 1'b0;
                        end
                    end
                    if (byte_cnt == CNT_FULL && xload_done) begin
                        state         <= COMPUTE;
                        input_load_en <= 1'b0;
                        ALU_en        <= 1'b1;
                    end
                end

                COMPUTE: begin
                    if (ALU_done) begin
                        ALU_en  <= 1'b0;
                        rd_idx  <= '0;
                        cs_n    <= 1'b0;
                        rd_addr <= rd_addr_of(RD_BASE, 0);
                        state   <= RD_REQ;
                    end
                end

                RD_REQ: begin
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (ry) begin
                        out_data  <= read_data;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end

                OUT: begin
                    // The next request is issued only after the current word is taken.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_idx == IDX_LAST) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            rd_idx  <= rd_idx + 1'b1;
                            cs_n    <= 1'b0;
                            rd_addr <= rd_addr_of(RD_BASE, int'(rd_idx) + 1);
                            state   <= RD_REQ;
                        end
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl: drivers push expectations, negedge monitors pop and compare.
module tb_matmul_ctrl;

    localparam int         N_BYTES    = 32;
    localparam int         N_RESULT   = 16;
    localparam logic [7:0] RD_BASE_TB = 8'h00;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  X_load;
    logic        valid_input;
    logic        input_load_en;
    logic        xload_done;
    logic        ALU_en;
    logic        ALU_done;
    logic        cs_n;
    logic [7:0]  rd_addr;
    logic        ry;
    logic [31:0] read_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    matmul_ctrl #(
        .N_BYTES  (N_BYTES),
        .N_RESULT (N_RESULT),
        .RD_BASE  (RD_BASE_TB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .X_load        (X_load),
        .valid_input   (valid_input),
        .input_load_en (input_load_en),
        .xload_done    (xload_done),
        .ALU_en        (ALU_en),
        .ALU_done      (ALU_done),
        .cs_n          (cs_n),
        .rd_addr       (rd_addr),
        .ry            (ry),
        .read_data     (read_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_x_q[$];
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_w_q[$];

    int ry_delay   = 0;
    int stall_idx  = -1;
    int stall_left = 0;
    int hs_count   = 0;
    int vi_count   = 0;
    int cs_pulses  = 0;
    int done_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    task automatic check_reset();
        chk("rst_in_ready",      32'(in_ready),      0);
        chk("rst_X_load",        32'(X_load),        0);
        chk("rst_valid_input",   32'(valid_input),   0);
        chk("rst_input_load_en", 32'(input_load_en), 0);
        chk("rst_ALU_en",        32'(ALU_en),        0);
        chk("rst_cs_n",          32'(cs_n),          1);
        chk("rst_rd_addr",       32'(rd_addr),       0);
        chk("rst_out_valid",     32'(out_valid),     0);
        chk("rst_out_data",      out_data,           0);
        chk("rst_busy",          32'(busy),          0);
        chk("rst_done",          32'(done),          0);
    endtask

    // X buffer monitor
    initial begin
        forever begin
            @(negedge clk);
            if (valid_input) begin
                if (exp_x_q.size() == 0) begin
                    chk("x_extra_valid_input", 32'(valid_input), 0);
                end else begin
                    chk("x_load_byte", 32'(X_load), 32'(exp_x_q.pop_front()));
                end
                vi_count++;
            end
        end
    end

    // SRAM request monitor
    initial begin
        logic prev_cs_n;
        prev_cs_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!cs_n) begin
                chk("cs_one_cycle", 32'(prev_cs_n), 1);
                chk("cs_while_out_valid", 32'(out_valid), 0);
                if (exp_addr_q.size() == 0) begin
                    chk("extra_read", 32'(cs_n), 1);
                end else begin
                    chk("rd_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
                end
                cs_pulses++;
            end
            prev_cs_n = cs_n;
        end
    end

    // SRAM model: answers each request after ry_delay extra cycles
    initial begin
        logic [7:0] a;
        ry = 1'b0;
        read_data = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (!cs_n) begin
                a = rd_addr;
                @(posedge clk); #1;
                for (int d = 0; d < ry_delay; d++) begin
                    @(posedge clk); #1;
                end
                ry = 1'b1;
                read_data = word_of(a);
                @(posedge clk); #1;
                ry = 1'b0;
                read_data = 32'hDEAD_BEEF;
            end
        end
    end

    // Result stream monitor
    initial begin
        logic        prev_ov;
        logic        prev_or;
        logic [31:0] prev_od;
        prev_ov = 1'b0;
        prev_or = 1'b1;
        prev_od = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_ov && !prev_or) begin
                chk("hold_out_valid", 32'(out_valid), 1);
                chk("hold_out_data", out_data, prev_od);
            end
            if (out_valid && out_ready) begin
                if (exp_w_q.size() == 0) begin
                    chk("extra_out_word", 32'(out_valid), 0);
                end else begin
                    chk("out_data", out_data, exp_w_q.pop_front());
                end
                hs_count++;
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end
    end

    // Done monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                chk("busy_during_done", 32'(busy), 1);
                done_count++;
            end
        end
    end

    // Downstream ready: stalls for 5 cycles when word stall_idx is presented
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (out_valid && hs_count == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic run_job(input logic [7:0] base, input bit gap, input bit extra,
                           input int alu_delay, input int rdly, input int stall_at,
                           input bit bad_start, input int abort_at);
        int n;
        int lat;
        ry_delay   = rdly;
        stall_idx  = stall_at;
        stall_left = (stall_at >= 0) ? 5 : 0;
        done_count = 0;
        hs_count   = 0;
        vi_count   = 0;
        cs_pulses  = 0;
        for (int i = 0; i < N_RESULT; i++) begin
            exp_addr_q.push_back(RD_BASE_TB + 8'(i));
            exp_w_q.push_back(word_of(RD_BASE_TB + 8'(i)));
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("load_en_in_load", 32'(input_load_en), 1);

        for (int i = 0; i < N_BYTES; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 100);
            if (in_ready) begin
                exp_x_q.push_back(in_data);
            end else begin
                chk("in_ready_timeout", 32'(in_ready), 1);
            end
            @(posedge clk); #1;
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 8'h55;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;

        if (extra) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("in_ready_when_full", 32'(in_ready), 0);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        xload_done = 1'b1;
        @(posedge clk); #1;
        xload_done = 1'b0;
        chk("alu_en_on", 32'(ALU_en), 1);

        for (int k = 0; k < alu_delay; k++) begin
            start = bad_start && (k == 3);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("alu_en_held", 32'(ALU_en), 1);

        ALU_done = 1'b1;
        @(posedge clk); #1;
        ALU_done = 1'b0;
        chk("alu_en_off", 32'(ALU_en), 0);

        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_out_latency", lat, 2 + rdly);

        if (abort_at >= 0) begin
            n = 0;
            while (hs_count < abort_at && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (cs_n && n < 100);
            chk("abort_read_issued", 32'(cs_n), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_reset();
            @(posedge clk); #1;
            rst = 1'b1;
            return;
        end

        n = 0;
        while (done_count == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_count, 1);
        chk("busy_after_job", 32'(busy), 0);
        chk("words_delivered", hs_count, N_RESULT);
        chk("bytes_loaded", vi_count, N_BYTES);
        chk("read_requests", cs_pulses, N_RESULT);
        chk("x_queue_drained", exp_x_q.size(), 0);
        chk("w_queue_drained", exp_w_q.size(), 0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        xload_done = 1'b0;
        ALU_done   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Nominal job
        run_job(8'h00, 1'b0, 1'b0, 20, 0, -1, 1'b0, -1);

        // Stray ry / ALU_done while idle
        done_count = 0;
        ry       = 1'b1;
        ALU_done = 1'b1;
        @(posedge clk); #1;
        ry       = 1'b0;
        ALU_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_cs_n", 32'(cs_n), 1);
            chk("idle_alu_en", 32'(ALU_en), 0);
        end
        chk("idle_no_done", done_count, 0);
        @(posedge clk); #1;

        // Gapped input, attempted 33rd byte, start during compute
        run_job(8'h80, 1'b1, 1'b1, 10, 0, -1, 1'b1, -1);

        // Backpressure on word 3
        run_job(8'h40, 1'b0, 1'b0, 5, 0, 3, 1'b0, -1);

        // Slow SRAM
        run_job(8'hC0, 1'b0, 1'b0, 5, 4, -1, 1'b0, -1);

        // Reset while waiting on word 7, then a full job
        run_job(8'h20, 1'b0, 1'b0, 5, 4, -1, 1'b0, 7);
        exp_x_q.delete();
        exp_addr_q.delete();
        exp_w_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_idle", 32'(busy), 0);
        run_job(8'h10, 1'b0, 1'b0, 8, 0, -1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter N_BYTES, default 32, number of X bytes loaded per job (4 x 64-bit X registers).
REQ-002 Parameter N_RESULT, default 16, number of 32-bit result words read back per job.
REQ-003 Parameter RD_BASE, default 8'h00, SRAM address of the first result word.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle job request.
REQ-007 in_valid / in_data  input  1 / 8  upstream byte stream.
REQ-008 in_ready  output  1  byte accepted on in_valid && in_ready.
REQ-009 X_load / valid_input / input_load_en  output  8 / 1 / 1  drive the X buffer.
REQ-010 xload_done  input  1  X buffer full.
REQ-011 ALU_en  output  1  compute enable.
REQ-012 ALU_done  input  1  compute and write-back complete.
REQ-013 cs_n  output  1  SRAM chip select, active-low.
REQ-014 rd_addr  output  8  SRAM read address.
REQ-015 ry / read_data  input  1 / 32  SRAM read-ready and data.
REQ-016 out_valid / out_data  output  1 / 32  result stream.
REQ-017 out_ready  input  1  result-stream backpressure.
REQ-018 busy / done  output  1 / 1  job active; single-cycle job-complete pulse.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, COMPUTE, RD_REQ, RD_WAIT, OUT, FIN.
REQ-020 IDLE: start -> LOAD; input_load_en=1 throughout LOAD; byte counter cleared.
REQ-021 LOAD: in_ready=1; each accepted byte is registered to X_load with valid_input=1 exactly one cycle later; the counter increments per accept.
REQ-022 LOAD exits to COMPUTE only when count==N_BYTES and xload_done=1; in_ready drops to 0 once count==N_BYTES.
REQ-023 COMPUTE: ALU_en=1 until ALU_done is sampled 1, then -> RD_REQ with read index=0; ALU_en=0 the following cycle.
REQ-024 RD_REQ: cs_n=0 and rd_addr=RD_BASE+index for exactly one cycle -> RD_WAIT.
REQ-025 RD_WAIT: on ry=1, capture read_data into out_data and go to OUT; cs_n=1 while waiting.
REQ-026 OUT: out_valid=1; out_data is held stable until out_valid && out_ready.
REQ-027 On handshake: index+1; if index==N_RESULT-1 -> FIN, else -> RD_REQ. Exactly one read is outstanding at any time.
REQ-028 FIN: done=1 for one cycle -> IDLE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 start while busy SHALL be ignored; in_valid outside LOAD SHALL not be accepted (in_ready=0).
REQ-031 ry=1 outside RD_WAIT and ALU_done outside COMPUTE SHALL be ignored.
REQ-032 Counter widths: $clog2(N_BYTES+1) and $clog2(N_RESULT); rd_addr arithmetic is 8-bit modulo 256.
REQ-033 Latency: first out_valid SHALL occur 2 cycles after ALU_done when ry returns in the cycle after the request.

Reset
REQ-034 rst low SHALL force IDLE and clear all counters, from any state including mid-job.
REQ-035 Reset values: in_ready=0, X_load=0, valid_input=0, input_load_en=0, ALU_en=0, cs_n=1, rd_addr=0, out_valid=0, out_data=0, busy=0, done=0.

Structure
REQ-036 The FSM state encoding and the N_BYTES/N_RESULT defaults SHALL live in the shared package (matmul_pkg).
REQ-037 The block SHALL be a single module; all outputs are registered; no sub-module.

Verification
REQ-038 Nominal job: start, 32 bytes 0x00..0x1F with no gaps, xload_done after the last byte, ALU_done 20 cycles later, ry one cycle after each request, out_ready=1 -> 16 words from addresses 0..15, one done pulse, busy low afterwards.
REQ-039 Gapped input: in_valid toggled 1/0 -> exactly 32 valid_input pulses carrying matching X_load values; no 33rd byte accepted.
REQ-040 Backpressure: out_ready=0 for 5 cycles on word 3 -> out_data stable, no new cs_n pulse until the handshake.
REQ-041 Slow SRAM: ry delayed 4 cycles per read -> cs_n low for exactly one cycle per word; 16 words delivered in order.
REQ-042 Illegal events: start during COMPUTE, plus ry and ALU_done pulses while IDLE -> no state change, no extra done.
REQ-043 Mid-job reset: rst low during RD_WAIT at word 7 -> all outputs at reset values; a new start runs a complete job from address RD_BASE.
